// File: rtl/fp_round_pack_if.sv
// Signal bundle for the round/pack stage: converter-side input word, packed output word
// and the saturation-count controls. The slave side is the stage; the master side feeds it.
interface fp_round_pack_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [2:0] in_exponent;
    logic [3:0] in_significand;
    logic       in_round;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_float;
    logic       out_sat;
    logic       sat_clr;
    logic [7:0] sat_count;

    modport master (
        output in_valid, in_sign, in_exponent, in_significand, in_round, out_ready, sat_clr,
        input  in_ready, out_valid, out_float, out_sat, sat_count
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_significand, in_round, out_ready, sat_clr,
        output in_ready, out_valid, out_float, out_sat, sat_count
    );
endinterface

// File: rtl/fp_round_pack.sv
// Round-half-up, renormalize and saturate a 1/3/4 float, delivered through a two-stage
// valid/ready pipeline, with a sticky count of saturated words handed to the consumer.
module fp_round_pack (
    input  logic           clk,
    input  logic           rst_n,
    fp_round_pack_if.slave bus
);
    logic       s1Valid_q, s1Valid_d;
    logic       s1Sign_q, s1Sign_d;
    logic [2:0] s1Exp_q, s1Exp_d;
    logic [4:0] s1Sum_q, s1Sum_d;
    logic       s2Valid_q, s2Valid_d;
    logic [7:0] s2Float_q, s2Float_d;
    logic       s2Sat_q, s2Sat_d;
    logic [7:0] satCount_q, satCount_d;

    logic       s2Advance;
    logic       inReady;
    logic       inXfer;
    logic       outXfer;
    logic [3:0] roundF;
    logic [2:0] roundE;
    logic       roundSat;

    // Carry out of the rounding add means the significand hit 16: halve it and bump the
    // exponent, unless the exponent is already at its ceiling, in which case clamp to max.
    always_comb begin
        roundF   = s1Sum_q[3:0];
        roundE   = s1Exp_q;
        roundSat = 1'b0;
        if (s1Sum_q[4]) begin
            if (s1Exp_q != 3'd7) begin
                roundF = 4'b1000;
                roundE = s1Exp_q + 3'd1;
            end else begin
                roundF   = 4'b1111;
                roundE   = 3'b111;
                roundSat = 1'b1;
            end
        end
    end

    always_comb begin
        s2Advance = ~s2Valid_q | bus.out_ready;
        inReady   = ~s1Valid_q | s2Advance;
        inXfer    = bus.in_valid & inReady;
        outXfer   = s2Valid_q & bus.out_ready;

        s1Valid_d  = s1Valid_q;
        s1Sign_d   = s1Sign_q;
        s1Exp_d    = s1Exp_q;
        s1Sum_d    = s1Sum_q;
        s2Valid_d  = s2Valid_q;
        s2Float_d  = s2Float_q;
        s2Sat_d    = s2Sat_q;
        satCount_d = satCount_q;

        if (inXfer) begin
            s1Valid_d = 1'b1;
            s1Sign_d  = bus.in_sign;
            s1Exp_d   = bus.in_exponent;
            s1Sum_d   = {1'b0, bus.in_significand} + {4'b0000, bus.in_round};
        end else if (s2Advance) begin
            s1Valid_d = 1'b0;
        end

        // An emptied S2 keeps its old data; only out_valid tells the consumer it is stale.
        if (s2Advance) begin
            s2Valid_d = s1Valid_q;
            if (s1Valid_q) begin
                s2Float_d = {s1Sign_q, roundE, roundF};
                s2Sat_d   = roundSat;
            end
        end

        if (bus.sat_clr) begin
            satCount_d = 8'd0;
        end else if (outXfer && s2Sat_q && (satCount_q != 8'hFF)) begin
            satCount_d = satCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1Exp_q    <= 3'd0;
            s1Sum_q    <= 5'd0;
            s2Valid_q  <= 1'b0;
            s2Float_q  <= 8'h00;
            s2Sat_q    <= 1'b0;
            satCount_q <= 8'd0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Sign_q   <= s1Sign_d;
            s1Exp_q    <= s1Exp_d;
            s1Sum_q    <= s1Sum_d;
            s2Valid_q  <= s2Valid_d;
            s2Float_q  <= s2Float_d;
            s2Sat_q    <= s2Sat_d;
            satCount_q <= satCount_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = s2Valid_q;
    assign bus.out_float = s2Float_q;
    assign bus.out_sat   = s2Sat_q;
    assign bus.sat_count = satCount_q;
endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: spec vectors from a table, randomized streams with
// backpressure against a normalize-loop reference model, saturation counting and reset cases.
module tb_fp_round_pack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fp_round_pack_if bus ();

    fp_round_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       sign;
        logic [2:0] e;
        logic [3:0] f;
        logic       r;
        logic [7:0] expFloat;
        logic       expSat;
    } vec_t;

    typedef struct {
        logic [7:0] f;
        logic       sat;
    } exp_t;

    exp_t expQ[$];
    int   nChecks  = 0;
    int   nFails   = 0;
    int   modelSat = 0;

    logic       smpInReady;
    logic       smpOutValid;
    logic       smpOutSat;
    logic [7:0] smpOutFloat;
    logic [7:0] smpSatCount;
    logic       prevStall = 1'b0;
    logic [7:0] prevFloat = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: value is (F+round) * 2^E; shift the significand down until it fits in 4 bits,
    // and anything needing an exponent beyond 7 clamps to the largest magnitude.
    function automatic exp_t refModel(input logic s, input logic [2:0] e, input logic [3:0] f, input logic r);
        exp_t res;
        int   m;
        int   ex;
        m  = int'(f) + int'(r);
        ex = int'(e);
        while (m > 15) begin
            m  = m / 2;
            ex = ex + 1;
        end
        if (ex > 7) begin
            res.f   = {s, 3'b111, 4'b1111};
            res.sat = 1'b1;
        end else begin
            res.f   = {s, ex[2:0], m[3:0]};
            res.sat = 1'b0;
        end
        return res;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later, score what the next rising edge will transfer.
    task automatic applyStimulus(input logic v, input logic s, input logic [2:0] e, input logic [3:0] f,
                                 input logic r, input logic ordy, input logic clr, output logic accepted);
        exp_t x;
        logic deliveredSat;
        int   occ;
        @(negedge clk);
        bus.in_valid       = v;
        bus.in_sign        = s;
        bus.in_exponent    = e;
        bus.in_significand = f;
        bus.in_round       = r;
        bus.out_ready      = ordy;
        bus.sat_clr        = clr;
        #1;
        smpInReady  = bus.in_ready;
        smpOutValid = bus.out_valid;
        smpOutFloat = bus.out_float;
        smpOutSat   = bus.out_sat;
        smpSatCount = bus.sat_count;
        occ = expQ.size();
        deliveredSat = 1'b0;
        checkOutput("inReady", 32'(smpInReady), 32'(!(occ == 2 && !ordy)));
        checkOutput("satCount", 32'(smpSatCount), 32'(modelSat));
        if (prevStall) begin
            checkOutput("stallValid", 32'(smpOutValid), 32'd1);
            checkOutput("stallFloat", 32'(smpOutFloat), 32'(prevFloat));
        end
        if (smpOutValid && ordy) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpectedOutput: got 0x%0h, expected no word", smpOutFloat);
            end else begin
                x = expQ.pop_front();
                checkOutput("outFloat", 32'(smpOutFloat), 32'(x.f));
                checkOutput("outSat", 32'(smpOutSat), 32'(x.sat));
                deliveredSat = x.sat;
            end
        end
        if (clr) modelSat = 0;
        else if (deliveredSat && modelSat < 255) modelSat++;
        prevStall = smpOutValid && !ordy;
        prevFloat = smpOutFloat;
        accepted  = v && smpInReady;
    endtask

    task automatic drainPipe();
        logic acc;
        for (int i = 0; i < 20 && expQ.size() > 0; i++)
            applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: got %0d words left, expected 0", expQ.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[11];
        exp_t x;
        logic acc;
        logic [2:0] re;
        logic [3:0] rf;
        logic rs, rr, ordy;
        int outCount;
        int w;

        vecs[0]  = '{1'b0, 3'd3, 4'b1011, 1'b1, 8'h3C, 1'b0};
        vecs[1]  = '{1'b0, 3'd2, 4'b1111, 1'b1, 8'h38, 1'b0};
        vecs[2]  = '{1'b0, 3'd6, 4'b1111, 1'b0, 8'h6F, 1'b0};
        vecs[3]  = '{1'b1, 3'd7, 4'b1111, 1'b1, 8'hFF, 1'b1};
        vecs[4]  = '{1'b0, 3'd0, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 4'b0000, 1'b0, 8'h80, 1'b0};
        vecs[6]  = '{1'b0, 3'd7, 4'b1110, 1'b1, 8'h7F, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 4'b1111, 1'b1, 8'h18, 1'b0};
        vecs[8]  = '{1'b0, 3'd6, 4'b1111, 1'b1, 8'h78, 1'b0};
        vecs[9]  = '{1'b1, 3'd5, 4'b0101, 1'b0, 8'hD5, 1'b0};
        vecs[10] = '{1'b0, 3'd7, 4'b1111, 1'b1, 8'h7F, 1'b1};

        bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exponent = 3'd0;
        bus.in_significand = 4'd0; bus.in_round = 1'b0; bus.out_ready = 1'b0; bus.sat_clr = 1'b0;
        #12;
        checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
        checkOutput("rstOutFloat", 32'(bus.out_float), 32'h00);
        checkOutput("rstOutSat", 32'(bus.out_sat), 32'd0);
        checkOutput("rstSatCount", 32'(bus.sat_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: accept at edge N, word visible after N+1.
        applyStimulus(1'b1, 1'b0, 3'd3, 4'b1011, 1'b1, 1'b1, 1'b0, acc);
        checkOutput("latAccept", 32'(acc), 32'd1);
        if (acc) expQ.push_back('{8'h3C, 1'b0});
        applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("latNotYet", 32'(smpOutValid), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("latPresent", 32'(smpOutValid), 32'd1);
        drainPipe();

        for (int i = 0; i < 11; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 5 && !acc; t++) begin
                applyStimulus(1'b1, vecs[i].sign, vecs[i].e, vecs[i].f, vecs[i].r, 1'b1, 1'b0, acc);
                if (acc) expQ.push_back('{vecs[i].expFloat, vecs[i].expSat});
            end
        end
        drainPipe();

        // Back-to-back stream with the consumer always ready.
        outCount = 0;
        for (int i = 0; i < 12; i++) begin
            rs = 1'($urandom); re = 3'($urandom); rf = 4'($urandom); rr = 1'($urandom);
            applyStimulus(1'b1, rs, re, rf, rr, 1'b1, 1'b0, acc);
            if (acc) expQ.push_back(refModel(rs, re, rf, rr));
            if (i >= 2 && smpOutValid) outCount++;
        end
        checkOutput("throughput", 32'(outCount), 32'd10);
        drainPipe();

        // 16 distinct words against a randomly stalling consumer.
        w = 0;
        rs = 1'($urandom); re = 3'($urandom); rr = 1'($urandom); rf = 4'd0;
        for (int c = 0; c < 300 && w < 16; c++) begin
            ordy = 1'($urandom);
            applyStimulus(1'b1, rs, re, rf, rr, ordy, 1'b0, acc);
            if (acc) begin
                expQ.push_back(refModel(rs, re, rf, rr));
                w++;
                rs = 1'($urandom); re = 3'($urandom); rr = 1'($urandom); rf = 4'(w);
            end
        end
        checkOutput("streamWords", 32'(w), 32'd16);
        drainPipe();

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd7, 4'b1111, 1'b1, 1'b1, 1'b0, acc);
            if (acc) expQ.push_back(refModel(1'b1, 3'd7, 4'b1111, 1'b1));
        end
        drainPipe();
        applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("satHold255", 32'(smpSatCount), 32'd255);

        // Clear coinciding with a saturating delivery: clear wins.
        applyStimulus(1'b1, 1'b1, 3'd7, 4'b1111, 1'b1, 1'b0, 1'b0, acc);
        if (acc) expQ.push_back(refModel(1'b1, 3'd7, 4'b1111, 1'b1));
        applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("clrWordWaiting", 32'(smpOutValid), 32'd1);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("satClrWins", 32'(smpSatCount), 32'd0);

        // Fill both stages under backpressure, then reset mid-stream.
        for (int c = 0; c < 10 && expQ.size() < 2; c++) begin
            applyStimulus(1'b1, 1'b0, 3'd4, 4'd9, 1'b0, 1'b0, 1'b0, acc);
            if (acc) expQ.push_back(refModel(1'b0, 3'd4, 4'd9, 1'b0));
        end
        applyStimulus(1'b1, 1'b0, 3'd1, 4'd1, 1'b0, 1'b0, 1'b0, acc);
        checkOutput("fullBlocks", 32'(acc), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("midRstInReady", 32'(bus.in_ready), 32'd1);
        expQ.delete();
        modelSat  = 0;
        prevStall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, acc);
            checkOutput("postRstEmpty", 32'(smpOutValid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/fp_round_pack.md
# fp_round_pack

Rounding and packing stage directly downstream of the linear-to-floating-point converter. Accepts the converter's sign, 3-bit exponent, 4-bit significand and the fifth (round) bit. It applies round-half-up, renormalizes on significand overflow, and saturates at the largest representable magnitude. It emits a packed 8-bit float through a two-stage valid/ready pipeline and keeps a saturating count of saturation events.

## Interface
- No parameters; all widths fixed by the 1/3/4 float format.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  stage can accept the input word this cycle.
- in_sign  input  1  sign of the original linear value.
- in_exponent  input  3  exponent from converter.
- in_significand  input  4  significand from converter.
- in_round  input  1  bit immediately below significand LSB.
- out_valid  output  1  packed word present.
- out_ready  input  1  consumer accepts the word this cycle.
- out_float  output  8  {sign, exponent[2:0], significand[3:0]}.
- out_sat  output  1  the word in out_float was saturated.
- sat_clr  input  1  synchronous clear of sat_count.
- sat_count  output  8  number of saturated words delivered, sticks at 255.

## Operation
- Stage 1 (S1) register: sign, exponent, sum[4:0] = {1'b0, in_significand} + in_round.
- Stage 2 (S2) register, computed from S1:
  - sum[4]=0: F = sum[3:0], E = exponent, sat = 0.
  - sum[4]=1 and exponent<7: F = 4'b1000, E = exponent+1, sat = 0.
  - sum[4]=1 and exponent=7: F = 4'b1111, E = 3'b111, sat = 1.
- Sign always passes through unchanged. Zero input (E=0, F=0, round=0) gives 0x00, or 0x80 when sign=1.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - S2 advances when S2 is empty or an output transfer occurs.
  - S1 advances into S2 when S1 is valid and S2 advances.
  - in_ready = ~s1_valid | (S2 advances). It is combinational from out_ready; no other combinational input-to-output paths exist.
  - Output data is held stable while out_valid=1 and out_ready=0.
- sat_count:
  - Increments by 1 on each output transfer with out_sat=1, holding at 255.
  - sat_clr forces it to 0. When sat_clr and an increment occur in the same cycle, clear wins: the result is 0 and that event is not counted.

## Timing
- Reset (rst_n low, asynchronous) sets s1_valid=0, s2_valid=0, out_valid=0, out_float=0x00, out_sat=0, sat_count=0, in_ready=1.
  - Reset mid-transfer discards both stages.
  - The first accept after release is possible on the first rising edge with rst_n high.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N+1, i.e. the earliest out transfer is at edge N+2.
- Throughput: 1 word/cycle while out_ready=1.
- Backpressure, out_ready=0:
  - S2 holds.
  - S1 accepts one more word, then in_ready drops to 0 (two words buffered).
  - When out_ready rises, in_ready rises in the same cycle and no word is lost or duplicated.
- Simultaneous accept and deliver with S1 full: legal. S1 moves to S2 and the new word enters S1 in the same edge.
- sat_count updates on the edge of the output transfer and is visible the following cycle.

## Test plan
- Reset, then in_sign=0, E=3, F=1011, round=1 with out_ready=1 -> out_float=0x3C two edges later, out_sat=0.
- E=2, F=1111, round=1 -> 0x38 (renormalized to E=3, F=1000). E=6, F=1111, round=0 -> 0x6F (no rounding).
- E=7, F=1111, round=1, sign=1 -> 0xFF, out_sat=1; sat_count goes to 1 after the transfer edge. Repeat 300 times -> sat_count holds 255. Then assert sat_clr together with a saturating transfer -> sat_count=0.
- Stream 16 distinct words with out_ready toggling pseudo-randomly:
  - Output order and values match a reference model exactly.
  - in_ready=0 only while both stages are full and out_ready=0.
  - out_float stays stable during each stall.
- Fill both stages with out_ready=0, pulse rst_n low mid-stream -> out_valid=0 and in_ready=1 immediately. No buffered words appear after release.
- Back-to-back words with out_ready held at 1 for 10 cycles -> 10 outputs on 10 consecutive cycles and in_ready constantly 1.
